// File: rtl/fp_mul_core_pkg.sv
// Shared types and constants for the single-precision multiply stage.
// Imported by the interface, the core and the normalise/round helper.
package fp_mul_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          MANT_W       = 24;
  localparam int          PROD_W       = 48;
  localparam int          DEFAULT_BIAS = 127;
  localparam logic [31:0] DEFAULT_QNAN = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX      = 8'hFF;

  function automatic logic is_nan_field(input logic [7:0] e, input logic [22:0] f);
    return (e == EXP_MAX) && (f != '0);
  endfunction

endpackage

// File: rtl/fp_mul_core_if.sv
// Operand/result handshake bundle between the field-split stage, the multiplier
// and its consumer. The core takes the slave view.
interface fp_mul_core_if;
  import fp_mul_core_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                a_s;
  logic                b_s;
  logic [7:0]          a_e;
  logic [7:0]          b_e;
  logic [MANT_W-1:0]   a_m;
  logic [MANT_W-1:0]   b_m;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         result;
  logic                overflow;
  logic                underflow;

  modport master (
    output in_valid, a_s, b_s, a_e, b_e, a_m, b_m, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, a_s, b_s, a_e, b_e, a_m, b_m, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );

endinterface

// File: rtl/fp_mul_core_norm_round.sv
// Combinational normalise, round-to-nearest-even and pack of a 48-bit mantissa
// product, with saturation to infinity and flush to zero at the exponent limits.
module fp_norm_round
  import fp_mul_core_pkg::*;
(
  input  logic [PROD_W-1:0] p,
  input  logic signed [9:0] e,
  input  logic              sign,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);

  logic [22:0]       mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       mant_rnd;
  logic signed [9:0] e_norm;
  logic signed [9:0] e_fin;

  always_comb begin
    mant      = p[45:23];
    guard     = p[22];
    sticky    = |p[21:0];
    e_norm    = e;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (p[47]) begin
      mant   = p[46:24];
      guard  = p[23];
      sticky = |p[22:0];
      e_norm = e + 10'sd1;
    end
    round_up = guard & (sticky | mant[0]);
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    mant_rnd = {1'b0, mant} + {23'b0, round_up};
    e_fin    = mant_rnd[23] ? e_norm + 10'sd1 : e_norm;
    result   = {sign, e_fin[7:0], mant_rnd[22:0]};
    if (e_fin >= 10'sd255) begin
      result   = {sign, EXP_MAX, 23'b0};
      overflow = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      result    = {sign, 31'b0};
      underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_core.sv
// Iterative shift-add IEEE-754 single-precision multiplier with valid/ready on both
// sides; fixed latency for every operand class, denormals flushed to zero.
module fp_mul_core
  import fp_mul_core_pkg::*;
#(
  parameter int          BITS_PER_CYCLE = 1,
  parameter int          BIAS           = DEFAULT_BIAS,
  parameter logic [31:0] QNAN           = DEFAULT_QNAN
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_core_if.slave bus
);

  localparam int         STEPS = MANT_W / BITS_PER_CYCLE;
  localparam logic [4:0] LAST  = 5'(STEPS - 1);

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic [PROD_W-1:0]   mcand;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   partial;
  logic [MANT_W-1:0]   mplier;
  logic [4:0]          counter;
  logic                sign_r;
  logic [7:0]          a_e_r;
  logic [7:0]          b_e_r;
  logic [22:0]         a_f_r;
  logic [22:0]         b_f_r;
  logic signed [9:0]   e_sum;
  logic                a_inf;
  logic                b_inf;
  logic                a_zero;
  logic                b_zero;
  logic [31:0]         nr_result;
  logic                nr_ovf;
  logic                nr_unf;
  logic [31:0]         result_d;
  logic                ovf_d;
  logic                unf_d;
  logic [31:0]         result_q;
  logic                ovf_q;
  logic                unf_q;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MUL;
      MUL:  if (counter == LAST) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = bus.in_valid ? MUL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplicand walks left and multiplier walks right so each step sees its bits at [0].
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      counter  <= '0;
      sign_r   <= 1'b0;
      a_e_r    <= '0;
      b_e_r    <= '0;
      a_f_r    <= '0;
      b_f_r    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (accept) begin
      mcand   <= {24'b0, bus.a_m};
      mplier  <= bus.b_m;
      prod    <= '0;
      counter <= '0;
      sign_r  <= bus.a_s ^ bus.b_s;
      a_e_r   <= bus.a_e;
      b_e_r   <= bus.b_e;
      a_f_r   <= bus.a_m[22:0];
      b_f_r   <= bus.b_m[22:0];
    end else if (state == MUL) begin
      prod    <= prod + partial;
      mcand   <= mcand << BITS_PER_CYCLE;
      mplier  <= mplier >> BITS_PER_CYCLE;
      counter <= counter + 5'd1;
    end else if (state == NORM) begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign e_sum  = $signed({2'b00, a_e_r} + {2'b00, b_e_r} - 10'(BIAS));
  assign a_inf  = (a_e_r == EXP_MAX) && (a_f_r == '0);
  assign b_inf  = (b_e_r == EXP_MAX) && (b_f_r == '0);
  assign a_zero = (a_e_r == 8'h00);
  assign b_zero = (b_e_r == 8'h00);

  fp_norm_round u_norm_round (
    .p         (prod),
    .e         (e_sum),
    .sign      (sign_r),
    .result    (nr_result),
    .overflow  (nr_ovf),
    .underflow (nr_unf)
  );

  // Special operands override the arithmetic path and never raise the flags.
  always_comb begin
    result_d = nr_result;
    ovf_d    = nr_ovf;
    unf_d    = nr_unf;
    if (is_nan_field(a_e_r, a_f_r) || is_nan_field(b_e_r, b_f_r) ||
        (a_inf && b_zero) || (b_inf && a_zero)) begin
      result_d = QNAN;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else if ((a_e_r == EXP_MAX) || (b_e_r == EXP_MAX)) begin
      result_d = {sign_r, EXP_MAX, 23'b0};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else if (a_zero || b_zero) begin
      result_d = {sign_r, 31'b0};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

endmodule
